// File: rtl/izh_ctrl_pkg.sv
// Shared definitions for the Izhikevich neuron controller: FSM state encoding,
// preset selector encoding, the Q8.8 preset parameter sets and the config frame length.
package izh_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PRESET_RS = 2'd0,
        PRESET_IB = 2'd1,
        PRESET_CH = 2'd2,
        PRESET_FS = 2'd3
    } preset_t;

    typedef struct packed {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [15:0] c;
        logic signed [15:0] d;
    } params_t;

    localparam int NUM_CFG_BYTES = 8;

    // Regular spiking
    localparam logic signed [15:0] RS_A = 16'sd5;
    localparam logic signed [15:0] RS_B = 16'sd51;
    localparam logic signed [15:0] RS_C = -16'sd16640;
    localparam logic signed [15:0] RS_D = 16'sd2048;
    // Intrinsically bursting
    localparam logic signed [15:0] IB_A = 16'sd5;
    localparam logic signed [15:0] IB_B = 16'sd51;
    localparam logic signed [15:0] IB_C = -16'sd14080;
    localparam logic signed [15:0] IB_D = 16'sd1024;
    // Chattering
    localparam logic signed [15:0] CH_A = 16'sd5;
    localparam logic signed [15:0] CH_B = 16'sd51;
    localparam logic signed [15:0] CH_C = -16'sd12800;
    localparam logic signed [15:0] CH_D = 16'sd512;
    // Fast spiking
    localparam logic signed [15:0] FS_A = 16'sd26;
    localparam logic signed [15:0] FS_B = 16'sd51;
    localparam logic signed [15:0] FS_C = -16'sd16640;
    localparam logic signed [15:0] FS_D = 16'sd512;

    // Returns the full a..d set for a preset selector value.
    function automatic params_t preset_params(input logic [1:0] sel);
        params_t p;
        p = '{a: RS_A, b: RS_B, c: RS_C, d: RS_D};
        case (preset_t'(sel))
            PRESET_IB: p = '{a: IB_A, b: IB_B, c: IB_C, d: IB_D};
            PRESET_CH: p = '{a: CH_A, b: CH_B, c: CH_C, d: CH_D};
            PRESET_FS: p = '{a: FS_A, b: FS_B, c: FS_C, d: FS_D};
            default:   p = '{a: RS_A, b: RS_B, c: RS_C, d: RS_D};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/izh_step_timer.sv
// Step divider for the neuron core: while active, emits a one-cycle enable pulse
// every step_div+1 cycles. The divisor is captured on entry/restart and at each wrap.
module izh_step_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       restart,
    input  logic [7:0] step_div,
    output logic       neuron_en
);

    logic [7:0] cnt;
    logic [7:0] div_q;

    // Divider counter; held at zero (and divisor re-captured) while idle or restarting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            div_q     <= '0;
            neuron_en <= 1'b0;
        end else if (!active || restart) begin
            cnt       <= '0;
            div_q     <= step_div;
            neuron_en <= 1'b0;
        end else if (cnt == div_q) begin
            cnt       <= '0;
            div_q     <= step_div;
            neuron_en <= 1'b1;
        end else begin
            cnt       <= cnt + 8'd1;
            neuron_en <= 1'b0;
        end
    end

endmodule

// File: rtl/izh_neuron_ctrl.sv
// Izhikevich neuron core sequencer/configurator. Loads a..d from an 8-byte
// little-endian stream into a shadow register or from a built-in preset, commits
// them atomically, paces the core enable and counts returned spikes.
// Optional build macro IZH_CTRL_LOAD_TIMEOUT_EN adds an inter-byte timeout on loads.
module izh_neuron_ctrl
    import izh_ctrl_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_valid,
    input  logic [7:0]              cfg_byte,
    output logic                    cfg_ready,
    input  logic                    preset_load,
    input  logic [1:0]              preset_sel,
    input  logic                    run_en,
    input  logic [7:0]              step_div,
    input  logic                    spike_in,
    input  logic                    cnt_clear,
    output logic signed [15:0]      param_a,
    output logic signed [15:0]      param_b,
    output logic signed [15:0]      param_c,
    output logic signed [15:0]      param_d,
    output logic                    params_ready,
    output logic                    neuron_en,
    output logic [CNT_W-1:0]        spike_count,
    output logic                    cfg_error,
    output logic [1:0]              state_o
);

    localparam logic [2:0]       LAST_IDX = 3'(NUM_CFG_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state;
    params_t    live;
    logic [2:0] byte_idx;
    logic [55:0] shadow;
    logic       cfg_accept;

`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    logic [GAP_W-1:0] gap;
    logic             cfg_error_r;
    assign cfg_error = cfg_error_r;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign cfg_error      = 1'b0;
`endif

    assign cfg_ready  = (state != ST_RUN);
    assign cfg_accept = cfg_valid & cfg_ready;
    assign state_o    = state;
    assign param_a    = live.a;
    assign param_b    = live.b;
    assign param_c    = live.c;
    assign param_d    = live.d;

    // Main FSM: shadow loading, atomic commit, presets and run gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            byte_idx     <= '0;
            shadow       <= '0;
            live         <= preset_params(PRESET_RS);
            params_ready <= 1'b0;
`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
            gap          <= '0;
            cfg_error_r  <= 1'b0;
`endif
        end else begin
`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
            cfg_error_r <= 1'b0;
`endif
            if (preset_load) begin
                live         <= preset_params(preset_sel);
                params_ready <= 1'b1;
                byte_idx     <= '0;
                if (state == ST_LOAD || (state == ST_RUN && !run_en)) begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg_accept) begin
                            shadow[7:0] <= cfg_byte;
                            byte_idx    <= 3'd1;
                            state       <= ST_LOAD;
`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
                            gap         <= '0;
`endif
                        end else if (run_en && params_ready) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_LOAD: begin
                        if (cfg_accept) begin
`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
                            gap <= '0;
`endif
                            if (byte_idx == LAST_IDX) begin
                                live.a       <= shadow[15:0];
                                live.b       <= shadow[31:16];
                                live.c       <= shadow[47:32];
                                live.d       <= {cfg_byte, shadow[55:48]};
                                params_ready <= 1'b1;
                                byte_idx     <= '0;
                                state        <= ST_IDLE;
                            end else begin
                                shadow[{byte_idx, 3'b000} +: 8] <= cfg_byte;
                                byte_idx <= byte_idx + 3'd1;
                            end
                        end
`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
                        else if (gap == GAP_W'(TIMEOUT_CYC - 1)) begin
                            byte_idx    <= '0;
                            gap         <= '0;
                            state       <= ST_IDLE;
                            cfg_error_r <= 1'b1;
                        end else begin
                            gap <= gap + 1'b1;
                        end
`endif
                    end
                    ST_RUN: begin
                        if (!run_en) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Saturating spike counter; clear wins over a simultaneous spike.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            spike_count <= '0;
        end else if (spike_in && spike_count != CNT_MAX) begin
            spike_count <= spike_count + 1'b1;
        end
    end

    izh_step_timer u_step_timer (
        .clk       (clk),
        .reset     (reset),
        .active    ((state == ST_RUN) && run_en),
        .restart   (preset_load),
        .step_div  (step_div),
        .neuron_en (neuron_en)
    );

endmodule

// File: tb/tb_izh_neuron_ctrl.sv
// Scoreboard bench for izh_neuron_ctrl: the driver predicts every cycle's outputs
// with a behavioural model and queues them; a monitor pops and compares each cycle.
// Honours IZH_CTRL_LOAD_TIMEOUT_EN in its model when the design is built with it.
module tb_izh_neuron_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [7:0]        cfg_byte = 8'h00;
    logic              cfg_ready;
    logic              preset_load = 1'b0;
    logic [1:0]        preset_sel = 2'd0;
    logic              run_en = 1'b0;
    logic [7:0]        step_div = 8'd0;
    logic              spike_in = 1'b0;
    logic              cnt_clear = 1'b0;
    logic signed [15:0] param_a, param_b, param_c, param_d;
    logic              params_ready, neuron_en, cfg_error;
    logic [7:0]        spike_count;
    logic [1:0]        state_o;

    always #5 clk = ~clk;

    izh_neuron_ctrl #(.CNT_W(8), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_byte(cfg_byte),
        .cfg_ready(cfg_ready), .preset_load(preset_load), .preset_sel(preset_sel),
        .run_en(run_en), .step_div(step_div), .spike_in(spike_in), .cnt_clear(cnt_clear),
        .param_a(param_a), .param_b(param_b), .param_c(param_c), .param_d(param_d),
        .params_ready(params_ready), .neuron_en(neuron_en), .spike_count(spike_count),
        .cfg_error(cfg_error), .state_o(state_o)
    );

    typedef struct {
        logic [1:0]         st;
        logic signed [15:0] a, b, c, d;
        logic               rdy, en, cr, err;
        logic [7:0]         cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    // Preset tables straight from the parameter sets (RS, IB, CH, FS)
    logic signed [15:0] pre_a [4] = '{16'sd5, 16'sd5, 16'sd5, 16'sd26};
    logic signed [15:0] pre_b [4] = '{16'sd51, 16'sd51, 16'sd51, 16'sd51};
    logic signed [15:0] pre_c [4] = '{-16'sd16640, -16'sd14080, -16'sd12800, -16'sd16640};
    logic signed [15:0] pre_d [4] = '{16'sd2048, 16'sd1024, 16'sd512, 16'sd512};

    // Reference model state: 0=IDLE 1=LOAD 2=RUN
    int                 m_state = 0;
    logic [7:0]         m_bytes[$];
    logic signed [15:0] m_a, m_b, m_c, m_d;
    logic               m_rdy = 1'b0, m_en = 1'b0, m_err = 1'b0;
    int                 m_cnt = 0, m_since = 0, m_gap = 0;

    logic       cur_re = 1'b0;
    logic [7:0] cur_sd = 8'd0;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic applyStimulus(input logic rst, input logic cv, input logic [7:0] cb,
                                 input logic pl, input logic [1:0] ps, input logic re,
                                 input logic [7:0] sd, input logic sp, input logic cc);
        int   nxt;
        exp_t e;
        @(negedge clk);
        reset = rst; cfg_valid = cv; cfg_byte = cb; preset_load = pl; preset_sel = ps;
        run_en = re; step_div = sd; spike_in = sp; cnt_clear = cc;
        if (rst) begin
            m_state = 0; m_bytes.delete();
            m_a = pre_a[0]; m_b = pre_b[0]; m_c = pre_c[0]; m_d = pre_d[0];
            m_rdy = 1'b0; m_en = 1'b0; m_err = 1'b0; m_cnt = 0; m_since = 0; m_gap = 0;
        end else begin
            nxt   = m_state;
            m_err = 1'b0;
            if (m_state == 2 && re && !pl) begin
                m_since++;
                m_en = (m_since == int'(sd) + 1);
                if (m_en) m_since = 0;
            end else begin
                m_en = 1'b0;
                m_since = 0;
            end
            if (cc) m_cnt = 0;
            else if (sp && m_cnt < 255) m_cnt++;
            if (pl) begin
                m_a = pre_a[ps]; m_b = pre_b[ps]; m_c = pre_c[ps]; m_d = pre_d[ps];
                m_rdy = 1'b1;
                m_bytes.delete();
                if (m_state == 1 || (m_state == 2 && !re)) nxt = 0;
            end else if (cv && m_state != 2) begin
                m_bytes.push_back(cb);
                m_gap = 0;
                if (m_bytes.size() == 8) begin
                    m_a = {m_bytes[1], m_bytes[0]};
                    m_b = {m_bytes[3], m_bytes[2]};
                    m_c = {m_bytes[5], m_bytes[4]};
                    m_d = {m_bytes[7], m_bytes[6]};
                    m_rdy = 1'b1;
                    m_bytes.delete();
                    nxt = 0;
                end else begin
                    nxt = 1;
                end
            end else if (m_state == 0 && re && m_rdy) begin
                nxt = 2;
            end else if (m_state == 2 && !re) begin
                nxt = 0;
            end else if (m_state == 1) begin
`ifdef IZH_CTRL_LOAD_TIMEOUT_EN
                m_gap++;
                if (m_gap == 255) begin
                    m_bytes.delete();
                    m_gap = 0;
                    m_err = 1'b1;
                    nxt = 0;
                end
`endif
            end
            m_state = nxt;
        end
        e.st = 2'(m_state); e.a = m_a; e.b = m_b; e.c = m_c; e.d = m_d;
        e.rdy = m_rdy; e.en = m_en; e.cr = (m_state != 2); e.err = m_err; e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, cur_re, cur_sd, 1'b0, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b, 1'b0, 2'd0, cur_re, cur_sd, 1'b0, 1'b0);
    endtask

    task automatic preset(input logic [1:0] s, input logic cv, input logic [7:0] b);
        applyStimulus(1'b0, cv, b, 1'b1, s, cur_re, cur_sd, 1'b0, 1'b0);
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("state_o",      16'(state_o),      16'(e.st));
        cmp("param_a",      param_a,           e.a);
        cmp("param_b",      param_b,           e.b);
        cmp("param_c",      param_c,           e.c);
        cmp("param_d",      param_d,           e.d);
        cmp("params_ready", 16'(params_ready), 16'(e.rdy));
        cmp("neuron_en",    16'(neuron_en),    16'(e.en));
        cmp("cfg_ready",    16'(cfg_ready),    16'(e.cr));
        cmp("cfg_error",    16'(cfg_error),    16'(e.err));
        cmp("spike_count",  16'(spike_count),  16'(e.cnt));
    endtask

    // Monitor: compare DUT outputs just after each edge against the queued prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput(mon_e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    logic [7:0] stream1 [8] = '{8'h05, 8'h00, 8'h33, 8'h00, 8'h00, 8'hBF, 8'h00, 8'h08};

    initial begin
        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Chattering preset from reset
        preset(2'd2, 1'b0, 8'h00);
        idle(2);

        // Full 8-byte stream giving the RS set
        for (int i = 0; i < 8; i++) sendByte(stream1[i]);
        idle(2);

        // Stepping with divider 3, then stop
        cur_re = 1'b1; cur_sd = 8'd3;
        idle(14);
        cur_re = 1'b0;
        idle(3);

        // Partial load aborted by an FS preset with a colliding byte, then a clean load
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
        preset(2'd3, 1'b1, 8'h44);
        idle(1);
        for (int i = 0; i < 8; i++) sendByte(8'($urandom));
        idle(2);

        // Divider 0, then a preset restart while running
        cur_re = 1'b1; cur_sd = 8'd0;
        idle(5);
        cur_re = 1'b0; idle(2);
        cur_re = 1'b1; cur_sd = 8'd2;
        idle(5);
        preset(2'd1, 1'b0, 8'h00);
        idle(7);
        cur_re = 1'b0; idle(2);

        // Spike saturation and clear-over-spike priority
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, cur_sd, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, cur_sd, 1'b1, 1'b1);
        idle(2);

        // Stalled load (times out only when the timeout option is built in)
        sendByte(8'hAA); sendByte(8'h55);
        idle(260);
        preset(2'd0, 1'b0, 8'h00);
        idle(2);

        // Reset in the middle of a load
        sendByte(8'h12); sendByte(8'h34);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, cur_sd, 1'b0, 1'b0);
        idle(2);

        // Randomized segments; the divider only changes while stepping is disabled
        for (int seg = 0; seg < 40; seg++) begin
            int len;
            len = int'($urandom_range(3, 15));
            cur_re = 1'($urandom_range(0, 1));
            if (!cur_re) cur_sd = 8'($urandom_range(0, 4));
            for (int i = 0; i < len; i++)
                applyStimulus(1'b0, ($urandom % 3) == 0, 8'($urandom), ($urandom % 20) == 0,
                              2'($urandom), cur_re, cur_sd, 1'($urandom), ($urandom % 50) == 0);
        end
        cur_re = 1'b0;
        idle(3);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
